// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Brief    : Shared constants and sizing helpers for the pipelined adder.
// Revision : 1.0
// ============================================================================

package adder_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic int occ_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ripple_carry_adder.sv
`default_nettype none
// ============================================================================
// Module   : ripple_carry_adder
// Brief    : Combinational WIDTH-bit ripple-carry adder with carry in/out.
// Revision : 1.0
// ============================================================================

module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    logic [WIDTH:0] w_carry;

    always_comb begin
        w_carry    = '0;
        sum        = '0;
        w_carry[0] = c_in;
        for (int k = 0; k < WIDTH; k++) begin
            sum[k]       = a[k] ^ b[k] ^ w_carry[k];
            w_carry[k+1] = (a[k] & b[k]) | (w_carry[k] & (a[k] ^ b[k]));
        end
    end

    assign c_out = w_carry[WIDTH];

endmodule

`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder
// Brief    : WIDTH-bit add/subtract split into STAGES carry-registered slices
//            with valid/ready handshakes and bubble-collapsing stalls.
// Revision : 1.0
// ============================================================================

module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_a,
    input  logic [WIDTH-1:0]              in_b,
    input  logic                          in_c,
    input  logic                          in_sub,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_sum,
    output logic                          out_c,
    output logic                          out_ovf,
    output logic [occ_width(STAGES)-1:0]  occupancy
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);
    localparam int OCC_W = occ_width(STAGES);
    localparam int LAST  = STAGES - 1;

    logic [WIDTH-1:0]  w_b_eff;
    logic              w_c_eff;
    logic [STAGES-1:0] w_vld;
    logic [STAGES:0]   w_rdy;
    logic              w_accept;
    logic              w_retire;
    logic              r_alive;
    logic [OCC_W-1:0]  r_occ;

    // Subtract is A + ~B + ~c, so the borrow-in is inverted alongside B.
    assign w_b_eff = (in_sub == ADD) ? in_b : ~in_b;
    assign w_c_eff = (in_sub == SUB) ? ~in_c : in_c;

    // Ready ripples backwards: a slice can load if it is empty or its successor loads.
    always_comb begin
        w_rdy         = '0;
        w_rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_rdy[k] = ~w_vld[k] | w_rdy[k+1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_slice
            localparam int LO  = gi * CHUNK;
            localparam int REM = WIDTH - LO;

            logic [REM-1:0]      w_a_src;
            logic [REM-1:0]      w_b_src;
            logic                w_c_src;
            logic                w_vld_src;
            logic                w_amsb_src;
            logic                w_bmsb_src;
            logic [CHUNK-1:0]    w_chunk;
            logic                w_cout;
            logic [LO+CHUNK-1:0] w_sum_nxt;

            logic [LO+CHUNK-1:0] r_sum;
            logic                r_vld;
            logic                r_c;
            logic                r_amsb;
            logic                r_bmsb;

            if (gi == 0) begin : g_src
                assign w_a_src    = in_a;
                assign w_b_src    = w_b_eff;
                assign w_c_src    = w_c_eff;
                assign w_vld_src  = in_valid & r_alive;
                assign w_amsb_src = in_a[WIDTH-1];
                assign w_bmsb_src = w_b_eff[WIDTH-1];
                assign w_sum_nxt  = w_chunk;
            end else begin : g_src
                assign w_a_src    = g_slice[gi-1].g_opnd.r_a;
                assign w_b_src    = g_slice[gi-1].g_opnd.r_b;
                assign w_c_src    = g_slice[gi-1].r_c;
                assign w_vld_src  = g_slice[gi-1].r_vld;
                assign w_amsb_src = g_slice[gi-1].r_amsb;
                assign w_bmsb_src = g_slice[gi-1].r_bmsb;
                assign w_sum_nxt  = {w_chunk, g_slice[gi-1].r_sum};
            end

            ripple_carry_adder #(
                .WIDTH (CHUNK)
            ) u_rca (
                .a     (w_a_src[CHUNK-1:0]),
                .b     (w_b_src[CHUNK-1:0]),
                .c_in  (w_c_src),
                .sum   (w_chunk),
                .c_out (w_cout)
            );

            // Each slice consumes the low chunk and forwards only the unused upper operands.
            if (gi < LAST) begin : g_opnd
                logic [REM-CHUNK-1:0] r_a;
                logic [REM-CHUNK-1:0] r_b;

                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        r_a <= '0;
                        r_b <= '0;
                    end else if (w_rdy[gi]) begin
                        r_a <= w_a_src[REM-1:CHUNK];
                        r_b <= w_b_src[REM-1:CHUNK];
                    end
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_vld  <= 1'b0;
                    r_sum  <= '0;
                    r_c    <= 1'b0;
                    r_amsb <= 1'b0;
                    r_bmsb <= 1'b0;
                end else if (w_rdy[gi]) begin
                    r_vld  <= w_vld_src;
                    r_sum  <= w_sum_nxt;
                    r_c    <= w_cout;
                    r_amsb <= w_amsb_src;
                    r_bmsb <= w_bmsb_src;
                end
            end

            assign w_vld[gi] = r_vld;
        end
    endgenerate

    // Holds off acceptance for the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

    assign in_ready = r_alive & w_rdy[0];
    assign w_accept = in_valid & in_ready;
    assign w_retire = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_occ <= '0;
        end else begin
            case ({w_accept, w_retire})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign occupancy = r_occ;
    assign out_valid = w_vld[LAST];
    assign out_sum   = g_slice[LAST].r_sum;
    assign out_c     = g_slice[LAST].r_c;
    assign out_ovf   = (g_slice[LAST].r_amsb == g_slice[LAST].r_bmsb) &&
                       (g_slice[LAST].r_sum[WIDTH-1] != g_slice[LAST].r_amsb);

endmodule

`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_adder
// Brief    : Directed self-checking bench for pipelined_adder (64/4 and 8/1).
// Revision : 1.0
// ============================================================================

module tb_pipelined_adder;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic        c;
        logic        sub;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, in_c, in_sub;
    logic        out_valid, out_ready, out_c, out_ovf;
    logic [63:0] in_a, in_b, out_sum;
    logic [2:0]  occupancy;

    logic        s1_in_valid, s1_in_ready, s1_in_c, s1_in_sub;
    logic        s1_out_valid, s1_out_ready, s1_out_c, s1_out_ovf;
    logic [7:0]  s1_in_a, s1_in_b, s1_out_sum;
    logic [0:0]  s1_occupancy;

    int checks = 0;
    int errors = 0;

    pipelined_adder #(.WIDTH(64), .STAGES(4)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_c     (out_c),
        .out_ovf   (out_ovf),
        .occupancy (occupancy)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s1_in_valid),
        .in_ready  (s1_in_ready),
        .in_a      (s1_in_a),
        .in_b      (s1_in_b),
        .in_c      (s1_in_c),
        .in_sub    (s1_in_sub),
        .out_valid (s1_out_valid),
        .out_ready (s1_out_ready),
        .out_sum   (s1_out_sum),
        .out_c     (s1_out_c),
        .out_ovf   (s1_out_ovf),
        .occupancy (s1_occupancy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string n, input logic [63:0] a, input logic [63:0] b,
                                input logic c, input logic sub, input logic [63:0] s,
                                input logic co, input logic ov);
        vec_t v;
        v.name = n; v.a = a; v.b = b; v.c = c; v.sub = sub;
        v.sum = s; v.cout = co; v.ovf = ov;
        return v;
    endfunction

    task automatic run64(input vec_t v);
        int lat;
        in_a = v.a; in_b = v.b; in_c = v.c; in_sub = v.sub;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({v.name, " in_ready"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({v.name, " latency"}, 64'(lat), 64'd4);
        chk({v.name, " sum"}, out_sum, v.sum);
        chk({v.name, " carry"}, 64'(out_c), 64'(v.cout));
        chk({v.name, " ovf"}, 64'(out_ovf), 64'(v.ovf));
        step();
        chk({v.name, " drained"}, 64'(occupancy), 64'd0);
    endtask

    task automatic run8(input string n, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic sub, input logic [7:0] s,
                        input logic co, input logic ov);
        int lat;
        s1_in_a = a; s1_in_b = b; s1_in_c = c; s1_in_sub = sub;
        s1_in_valid = 1'b1; s1_out_ready = 1'b1;
        step();
        s1_in_valid = 1'b0;
        lat = 1;
        while (!s1_out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({n, " latency"}, 64'(lat), 64'd1);
        chk({n, " sum"}, 64'(s1_out_sum), 64'(s));
        chk({n, " carry"}, 64'(s1_out_c), 64'(co));
        chk({n, " ovf"}, 64'(s1_out_ovf), 64'(ov));
        step();
        chk({n, " occupancy"}, 64'(s1_occupancy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int   sent, got, cyc;
        logic saw_full, held;
        logic [63:0] held_sum;

        vecs[0] = mk("add_wrap",  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
        vecs[1] = mk("sub_neg",   64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        vecs[2] = mk("sub_borrow",64'd7, 64'd5, 1'b1, 1'b1, 64'd1, 1'b1, 1'b0);
        vecs[3] = mk("add_ovf",   64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        vecs[4] = mk("sub_ovf",   64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        vecs[5] = mk("add_cin",   64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0);
        vecs[6] = mk("add_chunk", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
        vecs[7] = mk("sub_zero",  64'd0, 64'd0, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0);
        vecs[8] = mk("add_negovf",64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
        vecs[9] = mk("sub_cin",   64'd0, 64'd1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);

        reset = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_c = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        s1_in_valid = 1'b0; s1_in_a = '0; s1_in_b = '0; s1_in_c = 1'b0; s1_in_sub = 1'b0;
        s1_out_ready = 1'b1;

        #12;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst occupancy", 64'(occupancy), 64'd0);
        chk("rst out_sum", out_sum, 64'd0);
        chk("rst out_c", 64'(out_c), 64'd0);
        chk("rst out_ovf", 64'(out_ovf), 64'd0);
        chk("rst s1 out_valid", 64'(s1_out_valid), 64'd0);
        reset = 1'b1;
        step();
        chk("post-rst in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 10; i++) run64(vecs[i]);

        // Backpressure: 10 words A=B=k with a 6-cycle consumer stall.
        sent = 0; got = 0; cyc = 0; saw_full = 1'b0; held = 1'b0; held_sum = '0;
        in_c = 1'b0; in_sub = 1'b0;
        while (got < 10 && cyc < 80) begin
            out_ready = !(cyc >= 5 && cyc < 11);
            in_valid  = (sent < 10);
            in_a = 64'(sent); in_b = 64'(sent);
            #1;
            chk("bp in_ready", 64'(in_ready), 64'(!(occupancy == 3'd4 && !out_ready)));
            if (held) chk("bp hold", out_sum, held_sum);
            if (occupancy == 3'd4 && !out_ready) saw_full = 1'b1;
            held = out_valid && !out_ready;
            held_sum = out_sum;
            if (out_valid && out_ready) begin
                chk("bp order", out_sum, 64'(2 * got));
                got++;
            end
            if (in_valid && in_ready) sent++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        chk("bp saw_full", 64'(saw_full), 64'd1);
        chk("bp count", 64'(got), 64'd10);
        chk("bp occupancy", 64'(occupancy), 64'd0);
        chk("bp out_valid", 64'(out_valid), 64'd0);

        // Bubble collapse: two words separated by two idle cycles, consumer stalled.
        out_ready = 1'b0;
        in_a = 64'd100; in_b = 64'd1; in_valid = 1'b1;
        #1;
        chk("bub in_ready w0", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("bub in_ready idle", 64'(in_ready), 64'd1);
            step();
        end
        in_a = 64'd200; in_b = 64'd2; in_valid = 1'b1;
        #1;
        chk("bub in_ready w1", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("bub in_ready stall", 64'(in_ready), 64'd1);
            step();
        end
        chk("bub occupancy", 64'(occupancy), 64'd2);
        chk("bub out_valid", 64'(out_valid), 64'd1);
        chk("bub first", out_sum, 64'd101);
        out_ready = 1'b1;
        step();
        chk("bub second valid", 64'(out_valid), 64'd1);
        chk("bub second", out_sum, 64'd202);
        step();
        chk("bub drained", 64'(occupancy), 64'd0);

        // Reset with three words in flight.
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_a = 64'(k + 1); in_b = 64'd1; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("mid-rst out_valid", 64'(out_valid), 64'd0);
        chk("mid-rst occupancy", 64'(occupancy), 64'd0);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mid-rst stale", 64'(out_valid), 64'd0);
        end
        chk("mid-rst occ after", 64'(occupancy), 64'd0);
        run64(mk("post_rst", 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0));

        // Single-slice configuration.
        run8("s1_wrap", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        run8("s1_ovf",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run8("s1_sub",  8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
